// File: rtl/dkm_pkg.sv
// Shared state encoding, coin values and credit arithmetic for the dkm machine front end.
// Pure declarations; no timing or flow-control behaviour of its own.
package dkm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SVC     = 2'd1,
      ST_SESSION = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int CREDIT_W = 5;
   localparam logic [CREDIT_W-1:0] CREDIT_MAX  = 5'd31;
   localparam logic [CREDIT_W-1:0] VAL_NICKEL  = 5'd1;
   localparam logic [CREDIT_W-1:0] VAL_DIME    = 5'd2;
   localparam logic [CREDIT_W-1:0] VAL_QUARTER = 5'd5;

   function automatic logic [CREDIT_W-1:0] credit_add(input logic [CREDIT_W-1:0] a,
                                                      input logic [CREDIT_W-1:0] b);
      logic [CREDIT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CREDIT_W] ? CREDIT_MAX : sum[CREDIT_W-1:0];
   endfunction

endpackage

// File: rtl/dkm_panel_arbiter_if.sv
// Panel, service-port and dkm-facing signals of the panel arbiter in one bundle.
// master = panels/service/dkm side, slave = arbiter side; level requests, no backpressure.
interface dkm_panel_arbiter_if
   import dkm_pkg::*;
#(
   parameter int NP = 2
) ();

   logic [NP-1:0]       p_req;
   logic [NP-1:0]       p_nickel;
   logic [NP-1:0]       p_dime;
   logic [NP-1:0]       p_quarter;
   logic                svc_req;
   logic                svc_load_coins;
   logic                svc_load_cans;
   logic                dkm_empty;
   logic                dkm_dispense;

   logic [NP-1:0]       grant;
   logic                svc_gnt;
   logic                nickel_in;
   logic                dime_in;
   logic                quarter_in;
   logic                load_coins;
   logic                load_cans;
   logic [CREDIT_W-1:0] credit;
   logic                coin_rej;
   logic                abandon;

   modport master (
      output p_req, p_nickel, p_dime, p_quarter,
      output svc_req, svc_load_coins, svc_load_cans,
      output dkm_empty, dkm_dispense,
      input  grant, svc_gnt, nickel_in, dime_in, quarter_in,
      input  load_coins, load_cans, credit, coin_rej, abandon
   );

   modport slave (
      input  p_req, p_nickel, p_dime, p_quarter,
      input  svc_req, svc_load_coins, svc_load_cans,
      input  dkm_empty, dkm_dispense,
      output grant, svc_gnt, nickel_in, dime_in, quarter_in,
      output load_coins, load_cans, credit, coin_rej, abandon
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester strictly after ptr wins, one-hot grant plus its index.
// Purely combinational; no state, no backpressure.
module rr_arbiter #(
   parameter int NP = 2,
   parameter int PW = 1
) (
   input  logic [NP-1:0] req,
   input  logic [PW-1:0] ptr,
   output logic [NP-1:0] gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   int k;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = 0;
      for (int i = 1; i <= NP; i++) begin
         k = (int'(ptr) + i) % NP;
         if (!any && req[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = PW'(k);
         end
      end
   end

endmodule

// File: rtl/dkm_panel_arbiter.sv
// Shares one dkm machine between NP panels and a service port, forwarding the owner's coins.
// All outputs registered, 1-cycle latency; sessions cannot be preempted, losers simply wait.
module dkm_panel_arbiter
   import dkm_pkg::*;
#(
   parameter int NP      = 2,
   parameter int TIMEOUT = 16,
   parameter int TW      = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   dkm_panel_arbiter_if.slave bus
);

   localparam int PW = (NP > 1) ? $clog2(NP) : 1;

   state_t              state;
   logic [PW-1:0]       ptr;
   logic [TW-1:0]       tcnt;
   logic [NP-1:0]       grant;
   logic                svc_gnt;
   logic                nickel_in;
   logic                dime_in;
   logic                quarter_in;
   logic                load_coins;
   logic                load_cans;
   logic [CREDIT_W-1:0] credit;
   logic                coin_rej;
   logic                abandon;

   logic [NP-1:0]       rr_gnt;
   logic [PW-1:0]       rr_idx;
   logic                rr_any;

   logic                own_n;
   logic                own_d;
   logic                own_q;
   logic                own_any;
   logic                own_multi;
   logic [CREDIT_W-1:0] coin_val;

   rr_arbiter #(
      .NP (NP),
      .PW (PW)
   ) u_rr (
      .req (bus.p_req),
      .ptr (ptr),
      .gnt (rr_gnt),
      .idx (rr_idx),
      .any (rr_any)
   );

   // grant is one-hot (or zero outside a session), so masking isolates the owner's coins
   assign own_n     = |(bus.p_nickel  & grant);
   assign own_d     = |(bus.p_dime    & grant);
   assign own_q     = |(bus.p_quarter & grant);
   assign own_any   = own_n | own_d | own_q;
   assign own_multi = (own_q & (own_d | own_n)) | (own_d & own_n);

   always_comb begin
      coin_val = VAL_NICKEL;
      if (own_q)      coin_val = VAL_QUARTER;
      else if (own_d) coin_val = VAL_DIME;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= PW'(NP - 1);
         tcnt       <= '0;
         grant      <= '0;
         svc_gnt    <= 1'b0;
         nickel_in  <= 1'b0;
         dime_in    <= 1'b0;
         quarter_in <= 1'b0;
         load_coins <= 1'b0;
         load_cans  <= 1'b0;
         credit     <= '0;
         coin_rej   <= 1'b0;
         abandon    <= 1'b0;
      end else begin
         nickel_in  <= 1'b0;
         dime_in    <= 1'b0;
         quarter_in <= 1'b0;
         load_coins <= 1'b0;
         load_cans  <= 1'b0;
         coin_rej   <= 1'b0;
         abandon    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.svc_req) begin
                  state   <= ST_SVC;
                  svc_gnt <= 1'b1;
               end else if (!bus.dkm_empty && rr_any) begin
                  state  <= ST_SESSION;
                  grant  <= rr_gnt;
                  ptr    <= rr_idx;
                  credit <= '0;
                  tcnt   <= '0;
               end
            end
            ST_SVC: begin
               if (!bus.svc_req) begin
                  state   <= ST_IDLE;
                  svc_gnt <= 1'b0;
               end else begin
                  load_coins <= bus.svc_load_coins;
                  load_cans  <= bus.svc_load_cans;
               end
            end
            ST_SESSION: begin
               // dispense outranks both a coin and an expiring timer in the same cycle
               if (bus.dkm_dispense) begin
                  state    <= ST_DONE;
                  grant    <= '0;
                  credit   <= '0;
                  tcnt     <= '0;
                  coin_rej <= own_any;
               end else if (own_any) begin
                  quarter_in <= own_q;
                  dime_in    <= own_d & ~own_q;
                  nickel_in  <= own_n & ~own_d & ~own_q;
                  coin_rej   <= own_multi;
                  credit     <= credit_add(credit, coin_val);
                  tcnt       <= '0;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  state   <= ST_IDLE;
                  grant   <= '0;
                  credit  <= '0;
                  tcnt    <= '0;
                  abandon <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.grant      = grant;
   assign bus.svc_gnt    = svc_gnt;
   assign bus.nickel_in  = nickel_in;
   assign bus.dime_in    = dime_in;
   assign bus.quarter_in = quarter_in;
   assign bus.load_coins = load_coins;
   assign bus.load_cans  = load_cans;
   assign bus.credit     = credit;
   assign bus.coin_rej   = coin_rej;
   assign bus.abandon    = abandon;

endmodule

// File: tb/tb_dkm_panel_arbiter.sv
// Scoreboarded bench: a behavioural model queues the expected output word per driven cycle,
// and an independent monitor pops and compares one word after every rising edge.
module tb_dkm_panel_arbiter;
   import dkm_pkg::*;

   localparam int NP      = 2;
   localparam int TIMEOUT = 16;
   localparam int TW      = 5;
   localparam int VW      = NP + 13;
   localparam logic [NP-1:0] NO = 2'b00;
   localparam logic [NP-1:0] P0 = 2'b01;
   localparam logic [NP-1:0] P1 = 2'b10;
   localparam logic [NP-1:0] PB = 2'b11;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dkm_panel_arbiter_if #(.NP(NP)) bus ();

   dkm_panel_arbiter #(
      .NP      (NP),
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [VW-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   // model: mode 0 idle, 1 service, 2 session, 3 done; owner -1 when nobody holds the machine
   int m_mode, m_owner, m_last, m_credit, m_idle;
   bit m_svc;

   function automatic logic [VW-1:0] dut_vec();
      return {bus.grant, bus.svc_gnt, bus.nickel_in, bus.dime_in, bus.quarter_in,
              bus.load_coins, bus.load_cans, bus.credit, bus.coin_rej, bus.abandon};
   endfunction

   task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got grant/svc/n/d/q/lc/lcan/credit/rej/ab=%b expected %b",
                  name, $time, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0; m_owner = -1; m_last = NP - 1; m_credit = 0; m_idle = 0; m_svc = 0;
   endfunction

   function automatic void model_step(input logic [NP-1:0] req, n, d, q,
                                      input logic sr, lco, lca, emp, disp);
      logic [NP-1:0] g;
      bit nk, dm, qt, lc, lk, rej, ab;
      int cnt, v, c;
      bit found;
      g = '0; nk = 0; dm = 0; qt = 0; lc = 0; lk = 0; rej = 0; ab = 0;
      case (m_mode)
         0: begin
            if (sr) begin
               m_mode = 1; m_svc = 1;
            end else if (!emp && req != '0) begin
               found = 0;
               for (int s = 1; s <= NP; s++) begin
                  c = (m_last + s) % NP;
                  if (!found && req[c]) begin found = 1; m_owner = c; end
               end
               m_last = m_owner; m_mode = 2; m_credit = 0; m_idle = 0;
            end
         end
         1: begin
            if (!sr) begin m_mode = 0; m_svc = 0; end
            else begin lc = lco; lk = lca; end
         end
         2: begin
            cnt = int'(n[m_owner]) + int'(d[m_owner]) + int'(q[m_owner]);
            if (disp) begin
               m_mode = 3; m_owner = -1; m_credit = 0; rej = (cnt > 0);
            end else if (cnt > 0) begin
               if (q[m_owner])      begin v = 5; qt = 1; end
               else if (d[m_owner]) begin v = 2; dm = 1; end
               else                 begin v = 1; nk = 1; end
               rej = (cnt > 1);
               m_credit = (m_credit + v > 31) ? 31 : m_credit + v;
               m_idle = 0;
            end else begin
               m_idle++;
               if (m_idle >= TIMEOUT) begin
                  ab = 1; m_credit = 0; m_owner = -1; m_mode = 0;
               end
            end
         end
         default: m_mode = 0;
      endcase
      if (m_owner >= 0) g[m_owner] = 1'b1;
      exp_q.push_back({g, m_svc, nk, dm, qt, lc, lk, 5'(m_credit), rej, ab});
   endfunction

   task automatic cyc(input logic [NP-1:0] req, n, d, q, input logic sr, lco, lca, emp, disp);
      @(negedge clk);
      bus.p_req = req; bus.p_nickel = n; bus.p_dime = d; bus.p_quarter = q;
      bus.svc_req = sr; bus.svc_load_coins = lco; bus.svc_load_cans = lca;
      bus.dkm_empty = emp; bus.dkm_dispense = disp;
      model_step(req, n, d, q, sr, lco, lca, emp, disp);
   endtask

   task automatic idle(input int cycles, input logic [NP-1:0] req);
      for (int i = 0; i < cycles; i++) cyc(req, NO, NO, NO, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) check("outputs", dut_vec(), exp_q.pop_front());
      end
   end

   initial begin : stim
      logic [NP-1:0] rq, n, d, q;
      logic sr, emp, disp;
      int rate;
      bus.p_req = '0; bus.p_nickel = '0; bus.p_dime = '0; bus.p_quarter = '0;
      bus.svc_req = 0; bus.svc_load_coins = 0; bus.svc_load_cans = 0;
      bus.dkm_empty = 0; bus.dkm_dispense = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check("reset_state", dut_vec(), '0);
      @(negedge clk) rst_n = 1'b1;

      // build credit 7 in a panel 0 session, then reset asynchronously between edges
      cyc(P0, NO, NO, NO, 0, 0, 0, 0, 0);
      cyc(P0, NO, NO, P0, 0, 0, 0, 0, 0);
      cyc(P0, NO, P0, NO, 0, 0, 0, 0, 0);
      idle(1, P0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("async_reset", dut_vec(), '0);
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // two sessions with both panels requesting; foreign coins ignored, simultaneous coins
      cyc(PB, NO, NO, NO, 0, 0, 0, 0, 0);
      cyc(PB, NO, NO, P0, 0, 0, 0, 0, 0);
      cyc(PB, P1, NO, P1, 0, 0, 0, 0, 0);
      cyc(PB, NO, NO, P0, 0, 0, 0, 0, 0);
      cyc(PB, NO, P0, P0, 0, 0, 0, 0, 0);
      cyc(PB, NO, NO, NO, 0, 0, 0, 0, 1);
      idle(2, PB);
      cyc(PB, P0, NO, NO, 0, 0, 0, 0, 0);
      cyc(PB, PB, P1, NO, 0, 0, 0, 0, 0);
      cyc(PB, P1, NO, NO, 0, 0, 0, 0, 1);
      idle(3, NO);

      // timeout: one nickel then silence; owner drops its request meanwhile
      cyc(P0, NO, NO, NO, 0, 0, 0, 0, 0);
      cyc(P0, P0, NO, NO, 0, 0, 0, 0, 0);
      idle(TIMEOUT + 2, NO);

      // service first while empty, then the panel once the machine is restocked
      cyc(P0, NO, NO, NO, 1, 0, 0, 1, 0);
      cyc(P0, NO, NO, NO, 1, 0, 1, 1, 0);
      cyc(P0, NO, NO, NO, 1, 1, 0, 1, 0);
      cyc(P0, NO, NO, NO, 0, 1, 1, 1, 0);
      cyc(P0, NO, NO, NO, 0, 0, 0, 1, 0);
      cyc(P0, NO, NO, NO, 0, 0, 0, 0, 0);
      cyc(P0, NO, NO, NO, 1, 0, 0, 0, 0);
      cyc(P0, NO, P0, NO, 1, 0, 0, 0, 0);
      cyc(P0, NO, NO, NO, 1, 0, 0, 0, 1);
      cyc(NO, NO, NO, NO, 1, 0, 0, 0, 0);
      cyc(NO, NO, NO, NO, 1, 0, 0, 0, 0);
      cyc(NO, NO, NO, NO, 0, 0, 0, 0, 0);

      // randomized traffic with alternating dense and sparse coin phases
      rq = '0; sr = 0; emp = 0; rate = 4;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) rate = ($urandom_range(0, 1) == 0) ? 4 : 48;
         if ($urandom_range(0, 9) == 0) rq = NP'($urandom);
         if ($urandom_range(0, 39) == 0) sr = ~sr;
         if ($urandom_range(0, 29) == 0) emp = ($urandom_range(0, 3) == 0);
         for (int b = 0; b < NP; b++) begin
            n[b] = ($urandom_range(0, rate - 1) == 0);
            d[b] = ($urandom_range(0, rate - 1) == 0);
            q[b] = ($urandom_range(0, rate - 1) == 0);
         end
         disp = ($urandom_range(0, rate * 4 - 1) == 0);
         cyc(rq, n, d, q, sr, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), emp, disp);
      end
      idle(3, NO);

      @(posedge clk);
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL queue_drain: %0d expectations left, 0 required", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
